// File: rtl/mem_access_unit_pkg.sv
// Shared core package: request/state types and lane helpers for the memory access unit.
package mem_access_unit_pkg;

  // Access size as presented by the core; both 10 and 11 mean a full word.
  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_WORD     = 2'b10,
    SIZE_WORD_ALT = 2'b11
  } size_e;

  // Access sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_RESP
  } state_e;

  // Control fields of an accepted request that stay alive for the whole access.
  typedef struct packed {
    logic       write;
    logic       sext;
    size_e      size;
    logic [1:0] off;
    logic       split;
  } mem_op_t;

  // Byte-lane mask over two consecutive words: bits [3:0] are beat 0, bits [7:4] are beat 1.
  function automatic logic [7:0] lane_mask(size_e size, logic [1:0] off);
    logic [7:0] base;
    case (size)
      SIZE_BYTE: base = 8'h01;
      SIZE_HALF: base = 8'h03;
      default:   base = 8'h0F;
    endcase
    return base << off;
  endfunction

  // Right-aligned store data moved to its byte lanes over two consecutive words.
  function automatic logic [63:0] lane_place(logic [31:0] data, logic [1:0] off);
    return {32'h0, data} << {off, 3'b000};
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core request/response and memory bus signals of the memory access unit.
// The master modport is the unit itself; the slave modport is its environment (core + memory).
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_sext;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ack;

  modport master (
    input  req_valid, req_write, req_addr, req_size, req_sext, req_wdata,
    input  bus_rdata, bus_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_size, req_sext, req_wdata,
    output bus_rdata, bus_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/mem_access_unit_lane_extract.sv
// Load byte assembly: gathers the accessed bytes from one or two bus words and
// zero- or sign-extends them to 32 bits.
module lane_extract
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        sext,
  output logic [31:0] result
);

  logic [31:0] joined;

  // Shift the two-word window down so the first accessed byte lands in bits [7:0], then extend.
  always_comb begin
    joined = 32'({rdata_hi, rdata_lo} >> {off, 3'b000});
    case (size)
      SIZE_BYTE: result = {{24{sext & joined[7]}}, joined[7:0]};
      SIZE_HALF: result = {{16{sext & joined[15]}}, joined[15:0]};
      default:   result = joined;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns byte/half/word core loads and stores into one or two
// word-aligned bus beats, with per-beat timeout and little-endian lane handling.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  mem_access_unit_if.master io
);

  state_e      state;
  mem_op_t     op;
  logic [3:0]  be_hi;
  logic [31:0] wdata_hi;
  logic [31:0] rdata_lo;
  logic [31:0] wait_cnt;
  logic [7:0]  req_mask;
  logic [63:0] req_wpos;
  logic [31:0] extract_lo;
  logic [31:0] load_result;
  logic        beat_ack;
  logic        beat_timeout;

  // Decode the incoming request into lane masks and lane-positioned data for both beats.
  always_comb begin
    req_mask = lane_mask(size_e'(io.req_size), io.req_addr[1:0]);
    req_wpos = lane_place(io.req_wdata, io.req_addr[1:0]);
  end

  // An ack only counts while a beat is on the bus; the timeout fires on the cycle the wait count would reach TIMEOUT.
  always_comb begin
    beat_ack     = io.bus_req && io.bus_ack;
    beat_timeout = (TIMEOUT != 0) && ((wait_cnt + 32'd1) == TIMEOUT);
    extract_lo   = (state == ST_BEAT1) ? rdata_lo : io.bus_rdata;
  end

  lane_extract u_lane_extract (
    .rdata_lo (extract_lo),
    .rdata_hi (io.bus_rdata),
    .off      (op.off),
    .size     (op.size),
    .sext     (op.sext),
    .result   (load_result)
  );

  // Access sequencer: accept, issue one or two beats, then pulse the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      op           <= '0;
      be_hi        <= '0;
      wdata_hi     <= '0;
      rdata_lo     <= '0;
      wait_cnt     <= '0;
      io.req_ready <= 1'b1;
      io.bus_req   <= 1'b0;
      io.bus_we    <= 1'b0;
      io.bus_addr  <= '0;
      io.bus_be    <= '0;
      io.bus_wdata <= '0;
      io.rsp_valid <= 1'b0;
      io.rsp_rdata <= '0;
      io.rsp_error <= 1'b0;
    end else begin
      io.rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (io.req_valid) begin
            state        <= ST_BEAT0;
            op.write     <= io.req_write;
            op.sext      <= io.req_sext;
            op.size      <= size_e'(io.req_size);
            op.off       <= io.req_addr[1:0];
            op.split     <= |req_mask[7:4];
            be_hi        <= req_mask[7:4];
            wdata_hi     <= req_wpos[63:32];
            wait_cnt     <= '0;
            io.req_ready <= 1'b0;
            io.bus_req   <= 1'b1;
            io.bus_we    <= io.req_write;
            io.bus_addr  <= {io.req_addr[ADDR_W-1:2], 2'b00};
            io.bus_be    <= req_mask[3:0];
            io.bus_wdata <= req_wpos[31:0];
          end
        end
        ST_BEAT0, ST_BEAT1: begin
          if (beat_ack) begin
            wait_cnt <= '0;
            if (state == ST_BEAT0 && op.split) begin
              state        <= ST_BEAT1;
              rdata_lo     <= io.bus_rdata;
              io.bus_addr  <= io.bus_addr + ADDR_W'(4);
              io.bus_be    <= be_hi;
              io.bus_wdata <= wdata_hi;
            end else begin
              state        <= ST_RESP;
              io.bus_req   <= 1'b0;
              io.rsp_valid <= 1'b1;
              io.rsp_error <= 1'b0;
              io.rsp_rdata <= op.write ? 32'h0 : load_result;
            end
          end else if (beat_timeout) begin
            state        <= ST_RESP;
            wait_cnt     <= '0;
            io.bus_req   <= 1'b0;
            io.rsp_valid <= 1'b1;
            io.rsp_error <= 1'b1;
            io.rsp_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        ST_RESP: begin
          state        <= ST_IDLE;
          io.req_ready <= 1'b1;
        end
        default: begin
          state        <= ST_IDLE;
          io.req_ready <= 1'b1;
          io.bus_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed corner accesses plus randomized
// loads/stores with random ack delays, checked against a byte-level reference model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;

  mem_access_unit_if #(.ADDR_W(32)) io ();

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.master)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] expand_be(logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // One access from acceptance to the idle cycle after the response. Called right after a negedge.
  // dly0/dly1: cycles the memory waits before acking each beat (>= TIMEOUT means no ack).
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                               input logic sext, input logic [31:0] wdata, input int dly0,
                               input int dly1, input logic [31:0] rd0, input logic [31:0] rd1);
    int          n, off, nbeats, exp_issued, exp_lat, issued, cur_beat, beat_cycles, lat;
    int          dly [2];
    int          exp_high [2];
    int          high [2];
    logic [31:0] rd [2];
    logic [31:0] exp_addr [2];
    logic [3:0]  exp_be [2];
    logic [31:0] exp_wdata [2];
    logic [31:0] value, exp_rdata, obs_rdata;
    logic        exp_err, obs_err, seen;

    // Reference model: walk the accessed bytes one by one.
    n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    off = int'(addr[1:0]);
    nbeats = (off + n > 4) ? 2 : 1;
    dly[0] = dly0; dly[1] = dly1;
    rd[0] = rd0;   rd[1] = rd1;
    value = 32'h0;
    for (int b = 0; b < 2; b++) begin
      exp_addr[b]  = {addr[31:2], 2'b00} + 32'(4 * b);
      exp_be[b]    = 4'h0;
      exp_wdata[b] = 32'h0;
      exp_high[b]  = 0;
      high[b]      = 0;
    end
    for (int k = 0; k < n; k++) begin
      int pos, b, l;
      pos = off + k;
      b   = pos / 4;
      l   = pos % 4;
      exp_be[b][l] = 1'b1;
      exp_wdata[b][8*l +: 8] = wdata[8*k +: 8];
      value[8*k +: 8] = rd[b][8*l +: 8];
    end
    if (sext && n < 4 && value[8*n-1]) value = value | (32'hFFFFFFFF << (8 * n));
    exp_err = 1'b0; exp_issued = 0; exp_lat = 1;
    for (int b = 0; b < nbeats; b++) begin
      exp_issued++;
      if (dly[b] >= TIMEOUT) begin
        exp_high[b] = TIMEOUT;
        exp_lat += TIMEOUT;
        exp_err = 1'b1;
        break;
      end
      exp_high[b] = dly[b] + 1;
      exp_lat += dly[b] + 1;
    end
    exp_rdata = (wr || exp_err) ? 32'h0 : value;

    // Acceptance cycle; a stray ack here must be ignored.
    io.req_valid = 1'b1;
    io.req_write = wr;
    io.req_addr  = addr;
    io.req_size  = size;
    io.req_sext  = sext;
    io.req_wdata = wdata;
    io.bus_ack   = 1'($urandom);
    io.bus_rdata = $urandom;
    checkOutput("accept_ready", io.req_ready, 1);
    @(negedge clk);
    // Scramble the request fields; the unit must have latched them.
    io.req_valid = 1'b0;
    io.req_write = 1'($urandom);
    io.req_addr  = $urandom;
    io.req_size  = 2'($urandom);
    io.req_sext  = 1'($urandom);
    io.req_wdata = $urandom;

    issued = 0; cur_beat = 0; beat_cycles = 0; seen = 1'b0; lat = 0;
    obs_rdata = 32'h0; obs_err = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      if (io.rsp_valid) begin
        seen      = 1'b1;
        lat       = c;
        obs_rdata = io.rsp_rdata;
        obs_err   = io.rsp_error;
        checkOutput("resp_bus_req_low", io.bus_req, 0);
        io.bus_ack = 1'b0;
      end else begin
        if (io.bus_req && cur_beat < 2) begin
          if (beat_cycles == 0) issued++;
          checkOutput($sformatf("beat%0d_addr", cur_beat), io.bus_addr, exp_addr[cur_beat]);
          checkOutput($sformatf("beat%0d_be", cur_beat), io.bus_be, exp_be[cur_beat]);
          checkOutput($sformatf("beat%0d_we", cur_beat), io.bus_we, wr);
          checkOutput($sformatf("beat%0d_wdata", cur_beat),
                      io.bus_wdata & expand_be(exp_be[cur_beat]), exp_wdata[cur_beat]);
          high[cur_beat]++;
          if (beat_cycles == dly[cur_beat]) begin
            io.bus_ack   = 1'b1;
            io.bus_rdata = rd[cur_beat];
            cur_beat++;
            beat_cycles = 0;
          end else begin
            io.bus_ack   = 1'b0;
            io.bus_rdata = $urandom;
            beat_cycles++;
          end
        end else begin
          io.bus_ack = 1'b0;
          if (beat_cycles != 0) begin
            cur_beat++;
            beat_cycles = 0;
          end
        end
        @(negedge clk);
      end
    end

    checkOutput("rsp_seen", seen, 1);
    checkOutput("latency", lat, exp_lat);
    checkOutput("beats_issued", issued, exp_issued);
    for (int b = 0; b < exp_issued; b++)
      checkOutput($sformatf("beat%0d_req_cycles", b), high[b], exp_high[b]);
    checkOutput("rsp_error", obs_err, exp_err);
    checkOutput("rsp_rdata", obs_rdata, exp_rdata);
    last_rdata = obs_rdata;
    last_err   = obs_err;
    last_lat   = lat;

    // Idle cycle: pulse over, result held, stray ack ignored.
    @(negedge clk);
    checkOutput("rsp_pulse_len", io.rsp_valid, 0);
    checkOutput("idle_ready", io.req_ready, 1);
    checkOutput("rsp_rdata_hold", io.rsp_rdata, exp_rdata);
    checkOutput("rsp_error_hold", io.rsp_error, exp_err);
    io.bus_ack   = 1'($urandom);
    io.bus_rdata = $urandom;
    @(negedge clk);
    io.bus_ack = 1'b0;
  endtask

  // Split load whose second beat is pending when reset hits.
  task automatic applyResetMidAccess();
    logic got_rsp;
    io.req_valid = 1'b1;
    io.req_write = 1'b0;
    io.req_addr  = 32'h0000_0302;
    io.req_size  = 2'b10;
    io.req_sext  = 1'b0;
    io.req_wdata = 32'h0;
    io.bus_ack   = 1'b0;
    checkOutput("rst_accept_ready", io.req_ready, 1);
    @(negedge clk);
    io.req_valid = 1'b0;
    checkOutput("rst_beat0_req", io.bus_req, 1);
    io.bus_ack   = 1'b1;
    io.bus_rdata = $urandom;
    @(negedge clk);
    io.bus_ack = 1'b0;
    checkOutput("rst_beat1_addr", io.bus_addr, 32'h0000_0304);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_bus_req_low", io.bus_req, 0);
    checkOutput("rst_req_ready", io.req_ready, 1);
    checkOutput("rst_rsp_valid", io.rsp_valid, 0);
    checkOutput("rst_rsp_rdata", io.rsp_rdata, 0);
    checkOutput("rst_bus_be", io.bus_be, 0);
    @(negedge clk);
    rst = 1'b0;
    got_rsp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (io.rsp_valid) got_rsp = 1'b1;
    end
    checkOutput("rst_no_rsp", got_rsp, 0);
    checkOutput("rst_idle_ready", io.req_ready, 1);
  endtask

  // Main sequence: reset state, directed corners, reset abort, random traffic.
  initial begin
    logic [31:0] a;
    int          r, d0, d1;
    rst          = 1'b1;
    io.req_valid = 1'b0;
    io.req_write = 1'b0;
    io.req_addr  = 32'h0;
    io.req_size  = 2'b00;
    io.req_sext  = 1'b0;
    io.req_wdata = 32'h0;
    io.bus_ack   = 1'b0;
    io.bus_rdata = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready", io.req_ready, 1);
    checkOutput("reset_bus_req", io.bus_req, 0);
    checkOutput("reset_bus_we", io.bus_we, 0);
    checkOutput("reset_bus_addr", io.bus_addr, 0);
    checkOutput("reset_bus_be", io.bus_be, 0);
    checkOutput("reset_bus_wdata", io.bus_wdata, 0);
    checkOutput("reset_rsp_valid", io.rsp_valid, 0);
    checkOutput("reset_rsp_rdata", io.rsp_rdata, 0);
    checkOutput("reset_rsp_error", io.rsp_error, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed accesses");
    applyStimulus(1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0, 0, 0, 32'hDEADBEEF, 32'h0);
    checkOutput("word_load_value", last_rdata, 32'hDEADBEEF);
    checkOutput("word_load_latency", last_lat, 2);
    applyStimulus(1'b0, 32'h0000_0103, 2'b00, 1'b1, 32'h0, 0, 0, 32'h80123456, 32'h0);
    checkOutput("byte_load_sext", last_rdata, 32'hFFFFFF80);
    applyStimulus(1'b0, 32'h0000_0103, 2'b00, 1'b0, 32'h0, 0, 0, 32'h80123456, 32'h0);
    checkOutput("byte_load_zext", last_rdata, 32'h00000080);
    applyStimulus(1'b1, 32'h0000_0102, 2'b10, 1'b0, 32'h11223344, 0, 0, 32'h5555AAAA, 32'hAAAA5555);
    checkOutput("split_store_rdata", last_rdata, 32'h0);
    checkOutput("split_store_latency", last_lat, 3);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 2'b01, 1'b0, 32'h0, 0, 0, 32'hAB000000, 32'h000000CD);
    checkOutput("wrap_half_load", last_rdata, 32'h0000CDAB);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 2'b01, 1'b1, 32'h0, 1, 2, 32'hAB000000, 32'h000000CD);
    checkOutput("wrap_half_load_sext", last_rdata, 32'hFFFFCDAB);
    applyStimulus(1'b0, 32'h0000_0200, 2'b10, 1'b0, 32'h0, 255, 0, 32'h12345678, 32'h0);
    checkOutput("timeout_error", last_err, 1);
    checkOutput("timeout_rdata", last_rdata, 32'h0);
    applyStimulus(1'b0, 32'h0000_0200, 2'b10, 1'b0, 32'h0, TIMEOUT - 1, 0, 32'h12345678, 32'h0);
    checkOutput("late_ack_no_error", last_err, 0);
    checkOutput("late_ack_rdata", last_rdata, 32'h12345678);
    applyStimulus(1'b0, 32'h0000_0301, 2'b10, 1'b0, 32'h0, 0, 255, 32'h11111111, 32'h22222222);
    checkOutput("beat1_timeout_error", last_err, 1);

    $display("[TB] reset during second beat");
    applyResetMidAccess();
    applyStimulus(1'b0, 32'h0000_0402, 2'b10, 1'b0, 32'h0, 0, 0, 32'hBEEF0000, 32'h0000CAFE);
    checkOutput("post_reset_load", last_rdata, 32'hCAFEBEEF);

    $display("[TB] random accesses");
    for (int t = 0; t < 250; t++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = {30'h3FFFFFFF, a[1:0]};
      r  = $urandom_range(0, 11);
      d0 = (r < 8) ? r % 3 : (r < 11) ? TIMEOUT - 1 : TIMEOUT + 2;
      r  = $urandom_range(0, 11);
      d1 = (r < 8) ? r % 3 : (r < 11) ? TIMEOUT - 1 : TIMEOUT + 2;
      applyStimulus(1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, d0, d1, $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
